// File: rtl/mem_lsu_if.sv
// Data-memory bus between the load/store unit (master) and data memory (slave).
//   dmem_req_o    request, held until dmem_ack_i
//   dmem_we_o     1 = write
//   dmem_addr_o   word-aligned byte address
//   dmem_be_o     byte enables, lane 0 = bits 7:0
//   dmem_wdata_o  lane-replicated store data
//   dmem_ack_i    access complete; dmem_rdata_i valid in the same cycle
//   dmem_rdata_i  read word
interface mem_lsu_if;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    input  dmem_ack_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    output dmem_ack_i, dmem_rdata_i
  );
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit. Accepts one EX/MEM op while idle, runs a
// request/ack access on the data-memory bus, and produces a registered
// write-back result (one-cycle lsu_valid_o pulse).
//   clk, rst        clock, synchronous active-high reset
//   ex_*            op presented by the EX/MEM register (held while stall_o=1)
//   flush_i         kills the presented op, or the result of the op in flight
//   stall_o         1 while an access is outstanding
//   dmem            data-memory bus (master side)
//   lsu_*           write-back result, exception pulse and faulting address
module mem_lsu #(
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid_i,
  input  logic [3:0]        ex_op_i,
  input  logic [31:0]       ex_addr_i,
  input  logic [31:0]       ex_sdata_i,
  input  logic [31:0]       ex_wdata_i,
  input  logic [REG_AW-1:0] ex_waddr_i,
  input  logic              ex_we_i,
  input  logic              flush_i,
  output logic              stall_o,
  mem_lsu_if.master         dmem,
  output logic              lsu_valid_o,
  output logic [31:0]       lsu_wdata_o,
  output logic [REG_AW-1:0] lsu_waddr_o,
  output logic              lsu_we_o,
  output logic              lsu_exc_o,
  output logic              lsu_cause_o,
  output logic [31:0]       lsu_badaddr_o
);

  localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
                         OP_LW = 4'd5, OP_SB  = 4'd6, OP_SH = 4'd7, OP_SW  = 4'd8;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  function automatic logic [3:0] store_be(input logic [3:0] op, input logic [1:0] off);
    case (op)
      OP_SB:   store_be = 4'b0001 << off;
      OP_SH:   store_be = off[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] sd);
    case (op)
      OP_SB:   store_data = {4{sd[7:0]}};
      OP_SH:   store_data = {2{sd[15:0]}};
      default: store_data = sd;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [3:0] op, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = word >> {off, 3'b000};
    b  = sh[7:0];
    h  = off[1] ? word[31:16] : word[15:0];
    case (op)
      OP_LB:   load_ext = {{24{b[7]}}, b};
      OP_LBU:  load_ext = {24'h0, b};
      OP_LH:   load_ext = {{16{h[15]}}, h};
      OP_LHU:  load_ext = {16'h0, h};
      default: load_ext = word;
    endcase
  endfunction

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                kill_q, kill_d;
  logic [3:0]          op_q, op_d;
  logic [31:0]         addr_q, addr_d;
  logic [REG_AW-1:0]   rd_q, rd_d;
  logic                rdwe_q, rdwe_d;
  logic                req_q, req_d, dwe_q, dwe_d;
  logic [31:0]         daddr_q, daddr_d, dwdata_q, dwdata_d;
  logic [3:0]          dbe_q, dbe_d;
  logic                valid_q, valid_d, we_q, we_d, exc_q, exc_d, cause_q, cause_d;
  logic [31:0]         wdata_q, wdata_d, badaddr_q, badaddr_d;
  logic [REG_AW-1:0]   waddr_q, waddr_d;

  logic accept, is_mem, is_store, misalign, done_ack, done_to, killed;

  always_comb begin
    accept   = (state_q == S_IDLE) && ex_valid_i && !flush_i;
    is_mem   = (ex_op_i >= OP_LB) && (ex_op_i <= OP_SW);
    is_store = (ex_op_i >= OP_SB) && (ex_op_i <= OP_SW);
    misalign = (((ex_op_i == OP_LH) || (ex_op_i == OP_LHU) || (ex_op_i == OP_SH)) && ex_addr_i[0]) ||
               (((ex_op_i == OP_LW) || (ex_op_i == OP_SW)) && (ex_addr_i[1:0] != 2'b00));
    done_ack = (state_q == S_WAIT) && dmem.dmem_ack_i;
    // Ack wins over the timeout in the same cycle; TIMEOUT=0 disables the abort.
    done_to  = (state_q == S_WAIT) && !dmem.dmem_ack_i && (TIMEOUT != 0) &&
               (cnt_q == CNT_W'(TIMEOUT - 1));
    // A flush arriving in the completion cycle still suppresses the result.
    killed   = kill_q || flush_i;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;  cnt_q   <= '0;  kill_q  <= 1'b0;
      op_q    <= '0;      addr_q  <= '0;  rd_q    <= '0;    rdwe_q   <= 1'b0;
      req_q   <= 1'b0;    dwe_q   <= 1'b0; daddr_q <= '0;   dbe_q    <= '0;  dwdata_q <= '0;
      valid_q <= 1'b0;    wdata_q <= '0;  waddr_q <= '0;    we_q     <= 1'b0;
      exc_q   <= 1'b0;    cause_q <= 1'b0; badaddr_q <= '0;
    end else begin
      state_q <= state_d; cnt_q   <= cnt_d;  kill_q  <= kill_d;
      op_q    <= op_d;    addr_q  <= addr_d; rd_q    <= rd_d;    rdwe_q   <= rdwe_d;
      req_q   <= req_d;   dwe_q   <= dwe_d;  daddr_q <= daddr_d; dbe_q    <= dbe_d; dwdata_q <= dwdata_d;
      valid_q <= valid_d; wdata_q <= wdata_d; waddr_q <= waddr_d; we_q    <= we_d;
      exc_q   <= exc_d;   cause_q <= cause_d; badaddr_q <= badaddr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kill_d  = kill_q;
    op_d    = op_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    rdwe_d  = rdwe_q;
    case (state_q)
      S_IDLE: begin
        if (accept && is_mem && !misalign) begin
          state_d = S_WAIT;
          cnt_d   = '0;
          kill_d  = 1'b0;
          op_d    = ex_op_i;
          addr_d  = ex_addr_i;
          rd_d    = ex_waddr_i;
          rdwe_d  = ex_we_i;
        end
      end
      default: begin
        if (flush_i) kill_d = 1'b1;
        if (done_ack || done_to) begin
          state_d = S_IDLE;
          kill_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // Output logic: bus drive and registered write-back result
  always_comb begin
    req_d     = req_q;
    dwe_d     = dwe_q;
    daddr_d   = daddr_q;
    dbe_d     = dbe_q;
    dwdata_d  = dwdata_q;
    valid_d   = 1'b0;
    wdata_d   = '0;
    waddr_d   = '0;
    we_d      = 1'b0;
    exc_d     = 1'b0;
    cause_d   = 1'b0;
    badaddr_d = badaddr_q;
    if (accept) begin
      if (!is_mem) begin
        valid_d = 1'b1;
        wdata_d = ex_wdata_i;
        waddr_d = ex_waddr_i;
        we_d    = ex_we_i;
      end else if (misalign) begin
        valid_d   = 1'b1;
        exc_d     = 1'b1;
        badaddr_d = ex_addr_i;
      end else begin
        req_d    = 1'b1;
        dwe_d    = is_store;
        daddr_d  = {ex_addr_i[31:2], 2'b00};
        dbe_d    = is_store ? store_be(ex_op_i, ex_addr_i[1:0]) : 4'b1111;
        dwdata_d = is_store ? store_data(ex_op_i, ex_sdata_i) : '0;
      end
    end
    if (done_ack || done_to) req_d = 1'b0;
    if (done_ack && !killed) begin
      valid_d = 1'b1;
      if (op_q < OP_SB) begin
        wdata_d = load_ext(op_q, addr_q[1:0], dmem.dmem_rdata_i);
        waddr_d = rd_q;
        we_d    = rdwe_q;
      end
    end
    if (done_to && !killed) begin
      valid_d   = 1'b1;
      exc_d     = 1'b1;
      cause_d   = 1'b1;
      badaddr_d = addr_q;
    end
  end

  assign stall_o           = (state_q != S_IDLE);
  assign dmem.dmem_req_o   = req_q;
  assign dmem.dmem_we_o    = dwe_q;
  assign dmem.dmem_addr_o  = daddr_q;
  assign dmem.dmem_be_o    = dbe_q;
  assign dmem.dmem_wdata_o = dwdata_q;
  assign lsu_valid_o       = valid_q;
  assign lsu_wdata_o       = wdata_q;
  assign lsu_waddr_o       = waddr_q;
  assign lsu_we_o          = we_q;
  assign lsu_exc_o         = exc_q;
  assign lsu_cause_o       = cause_q;
  assign lsu_badaddr_o     = badaddr_q;

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;
  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [3:0]  ex_op;
  logic [31:0] ex_addr, ex_sdata, ex_wdata;
  logic [4:0]  ex_waddr;
  logic        ex_we, flush, stall;
  logic        lsu_valid, lsu_we, lsu_exc, lsu_cause;
  logic [31:0] lsu_wdata, lsu_badaddr;
  logic [4:0]  lsu_waddr;

  int n_chk  = 0;
  int n_fail = 0;

  mem_lsu_if bus ();

  mem_lsu #(.REG_AW(5), .TIMEOUT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid_i    (ex_valid),
    .ex_op_i       (ex_op),
    .ex_addr_i     (ex_addr),
    .ex_sdata_i    (ex_sdata),
    .ex_wdata_i    (ex_wdata),
    .ex_waddr_i    (ex_waddr),
    .ex_we_i       (ex_we),
    .flush_i       (flush),
    .stall_o       (stall),
    .dmem          (bus.master),
    .lsu_valid_o   (lsu_valid),
    .lsu_wdata_o   (lsu_wdata),
    .lsu_waddr_o   (lsu_waddr),
    .lsu_we_o      (lsu_we),
    .lsu_exc_o     (lsu_exc),
    .lsu_cause_o   (lsu_cause),
    .lsu_badaddr_o (lsu_badaddr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge: outputs are sampled and inputs driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] wdata, input logic [4:0] wa, input logic we);
    ex_valid = 1'b1; ex_op = op; ex_addr = addr; ex_sdata = sdata;
    ex_wdata = wdata; ex_waddr = wa; ex_we = we;
  endtask

  // Accept a memory op, capture the bus in the first WAIT cycle, ack in WAIT cycle nwait.
  // Returns at the cycle where the result should be visible.
  task automatic run_mem(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] wa, input int nwait, input logic [31:0] rdata,
                         output int nstall, output logic [31:0] c_addr, output logic [3:0] c_be,
                         output logic c_we, output logic [31:0] c_wdata, output logic c_req);
    present(op, addr, sdata, 32'h0, wa, 1'b1);
    tick();
    ex_valid = 1'b0;
    c_req = bus.dmem_req_o; c_addr = bus.dmem_addr_o; c_be = bus.dmem_be_o;
    c_we = bus.dmem_we_o; c_wdata = bus.dmem_wdata_o;
    nstall = 0;
    for (int i = 1; i <= nwait; i++) begin
      if (stall) nstall++;
      if (i == nwait) begin
        bus.dmem_ack_i = 1'b1;
        bus.dmem_rdata_i = rdata;
      end
      tick();
      bus.dmem_ack_i = 1'b0;
    end
  endtask

  int          ns, nreq, nvalid;
  logic [31:0] ca, cw;
  logic [3:0]  cb;
  logic        cwe, creq;

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_op = '0; ex_addr = '0; ex_sdata = '0; ex_wdata = '0;
    ex_waddr = '0; ex_we = 1'b0; flush = 1'b0;
    bus.dmem_ack_i = 1'b0; bus.dmem_rdata_i = '0;
    tick(); tick();
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_req", 32'(bus.dmem_req_o), 32'h0);
    chk("rst_valid", 32'(lsu_valid), 32'h0);
    chk("rst_badaddr", lsu_badaddr, 32'h0);
    rst = 1'b0;

    // NONE pass-through
    present(4'd0, 32'h0, 32'h0, 32'h1234, 5'd3, 1'b1);
    chk("none_stall0", 32'(stall), 32'h0);
    tick();
    ex_valid = 1'b0;
    chk("none_valid", 32'(lsu_valid), 32'h1);
    chk("none_wdata", lsu_wdata, 32'h1234);
    chk("none_waddr", 32'(lsu_waddr), 32'h3);
    chk("none_we", 32'(lsu_we), 32'h1);
    chk("none_stall1", 32'(stall), 32'h0);
    tick();
    chk("none_pulse", 32'(lsu_valid), 32'h0);
    chk("none_zero", lsu_wdata, 32'h0);

    // LB sign-extended, ack in third WAIT cycle
    run_mem(4'd1, 32'h103, 32'h0, 5'd5, 3, 32'h80FF_0000, ns, ca, cb, cwe, cw, creq);
    chk("lb_req", 32'(creq), 32'h1);
    chk("lb_daddr", ca, 32'h100);
    chk("lb_be", 32'(cb), 32'hF);
    chk("lb_dwe", 32'(cwe), 32'h0);
    chk("lb_stalls", 32'(ns), 32'd3);
    chk("lb_valid", 32'(lsu_valid), 32'h1);
    chk("lb_wdata", lsu_wdata, 32'hFFFF_FF80);
    chk("lb_waddr", 32'(lsu_waddr), 32'h5);
    chk("lb_we", 32'(lsu_we), 32'h1);
    chk("lb_stall_end", 32'(stall), 32'h0);
    chk("lb_req_end", 32'(bus.dmem_req_o), 32'h0);

    run_mem(4'd2, 32'h103, 32'h0, 5'd5, 3, 32'h80FF_0000, ns, ca, cb, cwe, cw, creq);
    chk("lbu_wdata", lsu_wdata, 32'h0000_0080);

    // Halfword and word loads
    run_mem(4'd3, 32'h102, 32'h0, 5'd6, 1, 32'h8001_7F00, ns, ca, cb, cwe, cw, creq);
    chk("lh_wdata", lsu_wdata, 32'hFFFF_8001);
    run_mem(4'd4, 32'h102, 32'h0, 5'd6, 2, 32'h8001_7F00, ns, ca, cb, cwe, cw, creq);
    chk("lhu_wdata", lsu_wdata, 32'h0000_8001);
    run_mem(4'd5, 32'h40, 32'h0, 5'd7, 1, 32'hDEAD_BEEF, ns, ca, cb, cwe, cw, creq);
    chk("lw_wdata", lsu_wdata, 32'hDEAD_BEEF);
    chk("lw_stalls", 32'(ns), 32'd1);

    // Stores
    run_mem(4'd7, 32'h22, 32'hAAAA_BEEF, 5'd9, 1, 32'h0, ns, ca, cb, cwe, cw, creq);
    chk("sh_be", 32'(cb), 32'hC);
    chk("sh_dwdata", cw, 32'hBEEF_BEEF);
    chk("sh_dwe", 32'(cwe), 32'h1);
    chk("sh_daddr", ca, 32'h20);
    chk("sh_valid", 32'(lsu_valid), 32'h1);
    chk("sh_we", 32'(lsu_we), 32'h0);
    run_mem(4'd6, 32'h101, 32'h1234_5678, 5'd9, 1, 32'h0, ns, ca, cb, cwe, cw, creq);
    chk("sb_be", 32'(cb), 32'h2);
    chk("sb_dwdata", cw, 32'h7878_7878);

    // Misaligned LW, then NONE accepted the following cycle
    present(4'd5, 32'h41, 32'h0, 32'h0, 5'd4, 1'b1);
    tick();
    present(4'd0, 32'h0, 32'h0, 32'h55, 5'd7, 1'b1);
    chk("mis_req", 32'(bus.dmem_req_o), 32'h0);
    chk("mis_valid", 32'(lsu_valid), 32'h1);
    chk("mis_exc", 32'(lsu_exc), 32'h1);
    chk("mis_cause", 32'(lsu_cause), 32'h0);
    chk("mis_badaddr", lsu_badaddr, 32'h41);
    chk("mis_we", 32'(lsu_we), 32'h0);
    chk("mis_stall", 32'(stall), 32'h0);
    tick();
    ex_valid = 1'b0;
    chk("mis_next_valid", 32'(lsu_valid), 32'h1);
    chk("mis_next_wdata", lsu_wdata, 32'h55);

    // Timeout with TIMEOUT=4
    present(4'd5, 32'h80, 32'h0, 32'h0, 5'd2, 1'b1);
    tick();
    ex_valid = 1'b0;
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      if (!bus.dmem_req_o) break;
      nreq++;
      tick();
    end
    chk("to_req_cycles", 32'(nreq), 32'd4);
    chk("to_valid", 32'(lsu_valid), 32'h1);
    chk("to_exc", 32'(lsu_exc), 32'h1);
    chk("to_cause", 32'(lsu_cause), 32'h1);
    chk("to_badaddr", lsu_badaddr, 32'h80);
    chk("to_we", 32'(lsu_we), 32'h0);
    bus.dmem_ack_i = 1'b1;
    tick();
    bus.dmem_ack_i = 1'b0;
    chk("late_ack_valid", 32'(lsu_valid), 32'h0);
    tick();
    chk("late_ack_valid2", 32'(lsu_valid), 32'h0);
    chk("late_ack_stall", 32'(stall), 32'h0);
    chk("badaddr_hold", lsu_badaddr, 32'h80);

    // Flush during WAIT: access completes, result suppressed
    present(4'd5, 32'h40, 32'h0, 32'h0, 5'd8, 1'b1);
    tick();
    ex_valid = 1'b0;
    nvalid = 0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    if (lsu_valid) nvalid++;
    tick();
    chk("fl_stall_at_ack", 32'(stall), 32'h1);
    bus.dmem_ack_i = 1'b1; bus.dmem_rdata_i = 32'h1111_2222;
    tick();
    bus.dmem_ack_i = 1'b0;
    if (lsu_valid) nvalid++;
    chk("fl_stall_after", 32'(stall), 32'h0);
    tick();
    if (lsu_valid) nvalid++;
    chk("fl_no_valid", 32'(nvalid), 32'h0);

    // Reset in the middle of WAIT
    present(4'd5, 32'h40, 32'h0, 32'h0, 5'd8, 1'b1);
    tick();
    ex_valid = 1'b0;
    chk("rw_req_before", 32'(bus.dmem_req_o), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rw_req", 32'(bus.dmem_req_o), 32'h0);
    chk("rw_stall", 32'(stall), 32'h0);
    chk("rw_daddr", bus.dmem_addr_o, 32'h0);
    chk("rw_be", 32'(bus.dmem_be_o), 32'h0);
    chk("rw_badaddr", lsu_badaddr, 32'h0);
    bus.dmem_ack_i = 1'b1;
    tick();
    bus.dmem_ack_i = 1'b0;
    chk("rw_no_valid", 32'(lsu_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
